// File: rtl/axi4l_regfile.sv
// rtl/axi4l_regfile.sv - AXI4-Lite register file slave; AXI4L_REGFILE_DECERR_EN enables DECERR on out-of-range access
module axi4l_regfile #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Write-side slots: address and data are captured independently and held until both are present
  logic                  aw_full;
  logic [IDX_W-1:0]      aw_idx_q;
  logic                  w_full;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;

  // Read side: a single outstanding read, captured at AR handshake
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  aw_fire;
  logic                  w_fire;
  logic                  b_fire;
  logic                  ar_fire;
  logic                  r_fire;
  logic                  commit;
  logic [IDX_W-1:0]      ar_idx;
  logic [NUM_REGS-1:0]   wr_sel;
  logic                  aw_hit;
  logic                  ar_hit;
  logic [DATA_WIDTH-1:0] rd_value;
  logic [1:0]            wr_resp;
  logic [1:0]            rd_resp;
  logic                  unused_addr_lsbs;

  // Byte-offset bits never select anything; they are dropped at decode
  assign unused_addr_lsbs = ^{AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

  // READYs are gated by reset so they read 0 while ARESETn is low and 1 right after release
  assign AWREADY = ARESETn & ~aw_full & ~bvalid_q;
  assign WREADY  = ARESETn & ~w_full & ~bvalid_q;
  assign ARREADY = ARESETn & ~rvalid_q;

  assign aw_fire = AWVALID & AWREADY;
  assign w_fire  = WVALID & WREADY;
  assign b_fire  = bvalid_q & BREADY;
  assign ar_fire = ARVALID & ARREADY;
  assign r_fire  = rvalid_q & RREADY;
  assign commit  = aw_full & w_full;
  assign ar_idx  = ARADDR[ADDR_WIDTH-1:ADDR_LSB];

  assign BVALID = bvalid_q;
  assign BRESP  = bresp_q;
  assign RVALID = rvalid_q;
  assign RDATA  = rdata_q;
  assign RRESP  = rresp_q;

  // Index decode for both paths; an index with no matching register is out of range
  always_comb begin
    wr_sel   = '0;
    rd_value = '0;
    ar_hit   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_idx_q == IDX_W'(i)) begin
        wr_sel[i] = 1'b1;
      end
      if (ar_idx == IDX_W'(i)) begin
        rd_value = regs_q[i];
        ar_hit   = 1'b1;
      end
    end
  end

  assign aw_hit = |wr_sel;

`ifdef AXI4L_REGFILE_DECERR_EN
  assign wr_resp = aw_hit ? RESP_OKAY : RESP_DECERR;
  assign rd_resp = ar_hit ? RESP_OKAY : RESP_DECERR;
`else
  logic unused_hits;
  assign unused_hits = aw_hit ^ ar_hit;
  assign wr_resp = RESP_OKAY;
  assign rd_resp = RESP_OKAY;
`endif

  // AW/W slot capture, release on commit, and write response generation
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_full  <= 1'b0;
      aw_idx_q <= '0;
      w_full   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (aw_fire) begin
        aw_full  <= 1'b1;
        aw_idx_q <= AWADDR[ADDR_WIDTH-1:ADDR_LSB];
      end else if (commit) begin
        aw_full <= 1'b0;
      end
      if (w_fire) begin
        w_full   <= 1'b1;
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end else if (commit) begin
        w_full <= 1'b0;
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
      end else if (b_fire) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Register array update, byte-masked by the held strobes
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_sel[i] && w_strb_q[b]) begin
            regs_q[i][b*8 +: 8] <= w_data_q[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read capture; samples the array before any same-edge commit lands
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_fire) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_value;
      rresp_q  <= rd_resp;
    end else if (r_fire) begin
      rvalid_q <= 1'b0;
    end
  end

  // Flatten the array onto the observation bus
  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

endmodule

// File: tb/tb_axi4l_regfile.sv
// tb/tb_axi4l_regfile.sv - self-checking bench for axi4l_regfile
module tb_axi4l_regfile;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;

`ifdef AXI4L_REGFILE_DECERR_EN
  localparam logic [1:0] OOR_RESP = 2'b11;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic           ACLK = 1'b0;
  logic           ARESETn = 1'b0;
  logic [AW-1:0]  AWADDR = '0;
  logic           AWVALID = 1'b0;
  logic           AWREADY;
  logic [DW-1:0]  WDATA = '0;
  logic [DW/8-1:0] WSTRB = '0;
  logic           WVALID = 1'b0;
  logic           WREADY;
  logic [1:0]     BRESP;
  logic           BVALID;
  logic           BREADY = 1'b0;
  logic [AW-1:0]  ARADDR = '0;
  logic           ARVALID = 1'b0;
  logic           ARREADY;
  logic [DW-1:0]  RDATA;
  logic [1:0]     RRESP;
  logic           RVALID;
  logic           RREADY = 1'b0;
  logic [NR*DW-1:0] regs_o;

  axi4l_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .regs_o(regs_o)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] model [NR];

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] raddr;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual=timeout required=handshake", name);
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'(a >> 2);
  endfunction

  function automatic logic [31:0] reg_of(input int i);
    return regs_o[i*32 +: 32];
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return (idx_of(a) < NR) ? 2'b00 : OOR_RESP;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return (idx_of(a) < NR) ? model[idx_of(a)] : 32'h0;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (idx_of(a) < NR) model[idx_of(a)] = (model[idx_of(a)] & ~mask) | (d & mask);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NR; i++) model[i] = 32'h0;
  endfunction

  // Full write: AW and W presented after independent delays, B accepted b_dly cycles after it appears
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly,
                          output logic [1:0] resp, output int b_lat);
    int cyc;
    bit aw_done, w_done, aw_f, w_f;
    cyc = 0; aw_done = 0; w_done = 0;
    resp = 2'bxx; b_lat = -1;
    while (!(aw_done && w_done)) begin
      AWADDR = addr; WDATA = data; WSTRB = strb;
      AWVALID = !aw_done && (cyc >= aw_dly);
      WVALID = !w_done && (cyc >= w_dly);
      aw_f = AWVALID && AWREADY;
      w_f = WVALID && WREADY;
      @(posedge ACLK); #1;
      aw_done = aw_done | aw_f;
      w_done = w_done | w_f;
      cyc++;
      if (cyc > 100) begin
        fail_timeout("write_addr_data_handshake");
        AWVALID = 0; WVALID = 0;
        return;
      end
    end
    AWVALID = 0; WVALID = 0;
    b_lat = 0;
    while (!BVALID) begin
      @(posedge ACLK); #1;
      b_lat++;
      if (b_lat > 50) begin
        fail_timeout("write_bvalid");
        return;
      end
    end
    resp = BRESP;
    repeat (b_dly) begin @(posedge ACLK); #1; end
    BREADY = 1;
    @(posedge ACLK); #1;
    BREADY = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                         output logic [31:0] data, output logic [1:0] resp);
    int cyc;
    bit f;
    cyc = 0; f = 0;
    data = 'x; resp = 'x;
    while (!f) begin
      ARADDR = addr;
      ARVALID = (cyc >= ar_dly);
      f = ARVALID && ARREADY;
      @(posedge ACLK); #1;
      cyc++;
      if (cyc > 100) begin
        fail_timeout("read_ar_handshake");
        ARVALID = 0;
        return;
      end
    end
    ARVALID = 0;
    check("rvalid_one_cycle_after_ar", RVALID, 1'b1);
    data = RDATA; resp = RRESP;
    repeat (r_dly) begin @(posedge ACLK); #1; end
    RREADY = 1;
    @(posedge ACLK); #1;
    RREADY = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=no_finish required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic [1:0] bresp, rresp;
    logic [31:0] rdata, exp_rd;
    int lat;
    bit seen_b;
    logic [31:0] wa, wd, ra;
    logic [3:0] ws;

    vecs[0] = '{32'h00, 32'h11223344, 4'hF, 32'h00, 32'h11223344, 2'b00};
    vecs[1] = '{32'h00, 32'hAABBCCDD, 4'h5, 32'h02, 32'h11BB33DD, 2'b00};
    vecs[2] = '{32'h3C, 32'hCAFEF00D, 4'hF, 32'h3C, 32'hCAFEF00D, 2'b00};
    vecs[3] = '{32'h3F, 32'h00000000, 4'h0, 32'h3D, 32'hCAFEF00D, 2'b00};
    vecs[4] = '{32'h40, 32'hFFFFFFFF, 4'hF, 32'h40, 32'h00000000, OOR_RESP};
    vecs[5] = '{32'h0E, 32'h99AABBCC, 4'h8, 32'h0C, 32'h99000000, 2'b00};

    model_clear();
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_awready", AWREADY, 1'b0);
    check("rst_wready", WREADY, 1'b0);
    check("rst_arready", ARREADY, 1'b0);
    check("rst_bvalid", BVALID, 1'b0);
    check("rst_rvalid", RVALID, 1'b0);
    check("rst_regs_any", |regs_o, 1'b0);
    @(negedge ACLK);
    ARESETn = 1;
    #1;
    check("rel_awready", AWREADY, 1'b1);
    check("rel_wready", WREADY, 1'b1);
    check("rel_arready", ARREADY, 1'b1);
    @(posedge ACLK); #1;

    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, 0, 0, 0, bresp, lat);
      model_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb);
      check($sformatf("vec%0d_bresp", i), bresp, vecs[i].exp_resp);
      do_read(vecs[i].raddr, 0, 0, rdata, rresp);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_rresp", i), rresp, vecs[i].exp_resp);
    end
    for (int i = 0; i < NR; i++) check($sformatf("table_reg%0d", i), reg_of(i), model[i]);

    // AW and W together, B accepted immediately
    do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, bresp, lat);
    model_write(32'h04, 32'hDEADBEEF, 4'hF);
    check("same_cycle_b_latency", lat, 1);
    check("same_cycle_bresp", bresp, 2'b00);
    check("same_cycle_reg1", reg_of(1), 32'hDEADBEEF);
    check("awready_after_b", AWREADY, 1'b1);
    check("wready_after_b", WREADY, 1'b1);

    // W first, AW five cycles later, partial strobe
    do_write(32'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 0, bresp, lat);
    do_write(32'h08, 32'h12345678, 4'h3, 5, 0, 2, bresp, lat);
    model_write(32'h08, 32'hFFFFFFFF, 4'hF);
    model_write(32'h08, 32'h12345678, 4'h3);
    check("late_aw_b_latency", lat, 1);
    check("late_aw_reg2", reg_of(2), 32'hFFFF5678);
    seen_b = 0;
    repeat (4) begin @(posedge ACLK); #1; seen_b = seen_b | BVALID; end
    check("late_aw_single_b", seen_b, 1'b0);

    // Read back-pressured for four cycles
    ARADDR = 32'h04; ARVALID = 1;
    @(posedge ACLK); #1;
    ARVALID = 0;
    for (int c = 0; c < 4; c++) begin
      check("stall_rvalid", RVALID, 1'b1);
      check("stall_rdata", RDATA, 32'hDEADBEEF);
      check("stall_arready", ARREADY, 1'b0);
      @(posedge ACLK); #1;
    end
    RREADY = 1;
    @(posedge ACLK); #1;
    RREADY = 0;
    check("stall_rvalid_cleared", RVALID, 1'b0);
    check("stall_arready_back", ARREADY, 1'b1);

    // Read capture on the same edge as a commit to the same register
    do_write(32'h14, 32'h55555555, 4'hF, 0, 0, 0, bresp, lat);
    AWADDR = 32'h14; WDATA = 32'hA5A5A5A5; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0; ARADDR = 32'h14; ARVALID = 1;
    @(posedge ACLK); #1;
    ARVALID = 0;
    check("collide_rdata_old", RDATA, 32'h55555555);
    check("collide_reg5_new", reg_of(5), 32'hA5A5A5A5);
    check("collide_bvalid", BVALID, 1'b1);
    BREADY = 1; RREADY = 1;
    @(posedge ACLK); #1;
    BREADY = 0; RREADY = 0;
    model_write(32'h14, 32'hA5A5A5A5, 4'hF);

    // Randomised concurrent write + read to different registers
    for (int it = 0; it < 120; it++) begin
      wa = ($urandom_range(0, 17) << 2) | $urandom_range(0, 3);
      ra = ($urandom_range(0, 17) << 2) | $urandom_range(0, 3);
      if (idx_of(wa) == idx_of(ra)) ra = ra ^ 32'h4;
      wd = $urandom;
      ws = 4'($urandom_range(0, 15));
      exp_rd = model_read(ra);
      fork
        do_write(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), bresp, lat);
        do_read(ra, $urandom_range(0, 3), $urandom_range(0, 3), rdata, rresp);
      join
      model_write(wa, wd, ws);
      check("rand_bresp", bresp, exp_resp(wa));
      check("rand_b_latency", lat, 1);
      check("rand_rdata", rdata, exp_rd);
      check("rand_rresp", rresp, exp_resp(ra));
    end
    for (int i = 0; i < NR; i++) check($sformatf("rand_reg%0d", i), reg_of(i), model[i]);

    // Reset with a write response and a read response pending
    AWADDR = 32'h18; WDATA = 32'h0BADF00D; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    ARADDR = 32'h04; ARVALID = 1;
    @(posedge ACLK); #1;
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    @(posedge ACLK); #1;
    check("pre_rst_bvalid", BVALID, 1'b1);
    #2 ARESETn = 0;
    #1;
    model_clear();
    check("arst_bvalid", BVALID, 1'b0);
    check("arst_rvalid", RVALID, 1'b0);
    check("arst_bresp", BRESP, 2'b00);
    check("arst_rresp", RRESP, 2'b00);
    check("arst_rdata", RDATA, 32'h0);
    check("arst_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
    check("arst_regs_any", |regs_o, 1'b0);
    @(negedge ACLK);
    ARESETn = 1;
    #1;
    check("arst_rel_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
    seen_b = 0;
    repeat (3) begin @(posedge ACLK); #1; seen_b = seen_b | BVALID; end
    check("arst_no_stale_b", seen_b, 1'b0);

    // Reset with only the AW slot full: the slot must be dropped
    AWADDR = 32'h20; AWVALID = 1;
    @(posedge ACLK); #1;
    AWVALID = 0;
    check("aw_slot_full_awready", AWREADY, 1'b0);
    ARESETn = 0;
    #2 ARESETn = 1;
    #1;
    check("aw_slot_dropped", AWREADY, 1'b1);
    WDATA = 32'h13572468; WSTRB = 4'hF; WVALID = 1;
    @(posedge ACLK); #1;
    WVALID = 0;
    seen_b = 0;
    repeat (4) begin @(posedge ACLK); #1; seen_b = seen_b | BVALID; end
    check("w_only_no_b", seen_b, 1'b0);
    check("w_only_reg8", reg_of(8), 32'h0);
    AWADDR = 32'h20; AWVALID = 1;
    @(posedge ACLK); #1;
    AWVALID = 0;
    @(posedge ACLK); #1;
    check("held_w_bvalid", BVALID, 1'b1);
    check("held_w_reg8", reg_of(8), 32'h13572468);
    BREADY = 1;
    @(posedge ACLK); #1;
    BREADY = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4l_regfile.md
AXI4L_REGFILE -- requirements
Module: axi4l_regfile
Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI4-Lite address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI4-Lite data width in bits (32 or 64).
REQ-003 SHALL have parameter NUM_REGS, default 16, number of DATA_WIDTH registers (>=1).
REQ-004 SHALL have ACLK  input  1  clock, all logic on rising edge.
REQ-005 SHALL have ARESETn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have AWADDR  input  ADDR_WIDTH  write address.
REQ-007 SHALL have AWVALID  input  1 / AWREADY  output  1  write-address handshake.
REQ-008 SHALL have WDATA  input  DATA_WIDTH  write data.
REQ-009 SHALL have WSTRB  input  DATA_WIDTH/8  write byte enables.
REQ-010 SHALL have WVALID  input  1 / WREADY  output  1  write-data handshake.
REQ-011 SHALL have BRESP  output  2  write response.
REQ-012 SHALL have BVALID  output  1 / BREADY  input  1  write-response handshake.
REQ-013 SHALL have ARADDR  input  ADDR_WIDTH  read address.
REQ-014 SHALL have ARVALID  input  1 / ARREADY  output  1  read-address handshake.
REQ-015 SHALL have RDATA  output  DATA_WIDTH / RRESP  output  2  read data and response.
REQ-016 SHALL have RVALID  output  1 / RREADY  input  1  read-data handshake.
REQ-017 SHALL have regs_o  output  NUM_REGS*DATA_WIDTH  register contents, register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
Function
REQ-018 SHALL decode register index = addr >> log2(DATA_WIDTH/8); low byte-offset bits ignored; index >= NUM_REGS is out-of-range.
REQ-019 SHALL accept AW and W independently: AWREADY = 1 while AW slot empty and BVALID=0; WREADY = 1 while W slot empty and BVALID=0; handshake loads slot.
REQ-020 SHALL commit on the edge after both slots are full: update in-range register per WSTRB byte, set BVALID=1, clear both slots.
REQ-021 SHALL give write latency: AW+W handshakes at edge T -> regs_o updated and BVALID=1 after edge T+1.
REQ-022 SHALL hold BRESP/BVALID stable until BREADY; B handshake clears BVALID, AWREADY/WREADY return 1 next cycle (one write per 3 cycles max).
REQ-023 SHALL hold AW slot if W arrives arbitrarily later (and vice versa) with no data loss.
REQ-024 SHALL drive ARREADY = NOT RVALID; AR handshake at edge T -> RVALID=1, RDATA=register value, RRESP after edge T.
REQ-025 SHALL hold RDATA/RRESP stable while RVALID=1 and RREADY=0; R handshake clears RVALID, ARREADY=1 same cycle after.
REQ-026 SHALL return pre-commit value when read capture and write commit occur on the same edge to the same register.
REQ-027 SHALL run read and write paths fully concurrently with no mutual stalling.
REQ-028 SHALL ignore out-of-range writes (no register change) and return RDATA=0 for out-of-range reads; BRESP/RRESP per REQ-033.
REQ-029 SHALL treat WSTRB=0 as a legal write that changes nothing and returns a normal response.
Reset
REQ-030 SHALL on ARESETn=0 asynchronously clear all registers, slots, BVALID, RVALID, BRESP, RRESP, RDATA to 0 and drive AWREADY/WREADY/ARREADY=0.
REQ-031 SHALL assert AWREADY/WREADY/ARREADY in the first cycle after ARESETn deasserts; in-flight transactions at reset are dropped.
Configuration
REQ-032 SHALL use macro AXI4L_REGFILE_DECERR_EN.
REQ-033 SHALL with macro defined respond DECERR (2'b11) on BRESP/RRESP for out-of-range access, OKAY (2'b00) otherwise; without it always OKAY.
Verification
REQ-034 SHALL test: AW addr 0x04 + W 0xDEADBEEF strb 0xF same cycle, BREADY=1 -> BVALID 2 cycles later, BRESP=0, regs_o[1]=0xDEADBEEF.
REQ-035 SHALL test: W 0x12345678 strb 0x3 to addr 0x08 (reg=0xFFFFFFFF), AW 5 cycles later -> reg2=0xFFFF5678, single B response.
REQ-036 SHALL test: AR addr 0x04 with RREADY=0 for 4 cycles -> RVALID held, RDATA=0xDEADBEEF stable, ARREADY=0 until handshake.
REQ-037 SHALL test: AR addr 0x40 (NUM_REGS=16) -> RDATA=0, RRESP=2'b11 with macro, 2'b00 without; write to 0x40 changes no register.
REQ-038 SHALL test: ARESETn low while BVALID=1 and AW slot full -> all outputs 0, regs_o=0; after release READYs=1, no stale B.
